// File: rtl/pio_pkg.sv
// Shared constants, request encoding and count decode for the PIO shift registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pio_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  // Shift counter value meaning "every bit consumed".
  localparam logic [CNT_W-1:0] FULL_CNT = 6'd32;

  // Winning request after priority resolution (mov > pull > out).
  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_MOV,
    REQ_PULL,
    REQ_OUT
  } req_t;

  // 5-bit instruction count fields cannot express 32, so 0 stands for 32.
  function automatic logic [CNT_W-1:0] decode_cnt(input logic [4:0] f);
    return (f == 5'd0) ? FULL_CNT : {1'b0, f};
  endfunction

endpackage

// File: rtl/pio_osr_shifter.sv
// Combinational n-bit extract-and-shift used by the OSR (and later the ISR).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: osr (current register), n (1..32 bits), dir (1=right/LSB first),
//        out_data (extracted bits, zero-extended), osr_next (shifted register).
module pio_osr_shifter
  import pio_pkg::*;
(
  input  logic [DATA_W-1:0] osr,
  input  logic [CNT_W-1:0]  n,
  input  logic              dir,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] osr_next
);

  logic [DATA_W-1:0] low_mask;
  logic [CNT_W-1:0]  back;

  assign low_mask = ~({DATA_W{1'b1}} << n);
  assign back     = FULL_CNT - n;

  always_comb begin
    out_data = '0;
    osr_next = '0;
    if (n >= FULL_CNT) begin
      // Full-width move handled explicitly so the whole word comes out
      // and the register empties regardless of shift direction.
      out_data = osr;
      osr_next = '0;
    end else if (dir == SHIFT_RIGHT) begin
      out_data = osr & low_mask;
      osr_next = osr >> n;
    end else begin
      out_data = osr >> back;
      osr_next = osr << n;
    end
  end

endmodule

// File: rtl/pio_osr.sv
// PIO output shift register: drains the TX FIFO and serves OUT/PULL/MOV requests.
// Latency: state updates at the next clk edge; out_data/out_valid one cycle after OUT completes.
// Backpressure: stall held while PULL blocks on an empty FIFO or OUT waits for an autopull refill.
// Ports: clk/reset_n (sync active-low), en, shift config (shift_right, autopull, pull_thresh),
//        instruction requests (out_*, pull_*, mov_*), TX FIFO read side (fifo_empty, fifo_dout,
//        fifo_pull), results (stall, out_data, out_valid, osr_count, osr_value).
module pio_osr
  import pio_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              shift_right,
  input  logic              autopull,
  input  logic [4:0]        pull_thresh,
  input  logic              out_req,
  input  logic [4:0]        out_count,
  input  logic              pull_req,
  input  logic              pull_block,
  input  logic              pull_ifempty,
  input  logic [DATA_W-1:0] pull_x,
  input  logic              mov_req,
  input  logic [DATA_W-1:0] mov_data,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_pull,
  output logic              stall,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [CNT_W-1:0]  osr_count,
  output logic [DATA_W-1:0] osr_value
);

  logic [DATA_W-1:0] osr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  thr;
  logic [CNT_W-1:0]  n;
  logic              need_refill;
  req_t              winner;

  logic              load;
  logic [DATA_W-1:0] load_val;
  logic              do_out;

  logic [DATA_W-1:0] shift_out;
  logic [DATA_W-1:0] shift_next;
  logic [CNT_W:0]    cnt_sum;

  assign thr         = decode_cnt(pull_thresh);
  assign n           = decode_cnt(out_count);
  assign need_refill = autopull && (count >= thr);
  assign cnt_sum     = {1'b0, count} + {1'b0, n};

  pio_osr_shifter u_shifter (
    .osr      (osr),
    .n        (n),
    .dir      (shift_right),
    .out_data (shift_out),
    .osr_next (shift_next)
  );

  // Only one request acts per cycle; reset and en=0 suppress everything.
  always_comb begin
    winner = REQ_IDLE;
    if (reset_n && en) begin
      if (mov_req)       winner = REQ_MOV;
      else if (pull_req) winner = REQ_PULL;
      else if (out_req)  winner = REQ_OUT;
    end
  end

  always_comb begin
    fifo_pull = 1'b0;
    stall     = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    do_out    = 1'b0;
    case (winner)
      REQ_MOV: begin
        load     = 1'b1;
        load_val = mov_data;
      end
      REQ_PULL: begin
        // ifempty with the register not yet drained to threshold is a no-op.
        if (!(pull_ifempty && (count < thr))) begin
          if (!fifo_empty) begin
            fifo_pull = 1'b1;
            load      = 1'b1;
            load_val  = fifo_dout;
          end else if (pull_block) begin
            stall = 1'b1;
          end else begin
            load     = 1'b1;
            load_val = pull_x;
          end
        end
      end
      REQ_OUT: begin
        if (need_refill) begin
          // Refill this cycle, execute the held OUT on the next one.
          stall = 1'b1;
          if (!fifo_empty) begin
            fifo_pull = 1'b1;
            load      = 1'b1;
            load_val  = fifo_dout;
          end
        end else begin
          do_out = 1'b1;
        end
      end
      REQ_IDLE: begin
        // Background autopull while the execute stage has nothing for us.
        if (reset_n && en && need_refill && !fifo_empty) begin
          fifo_pull = 1'b1;
          load      = 1'b1;
          load_val  = fifo_dout;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      osr       <= '0;
      count     <= FULL_CNT;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= do_out;
      if (load) begin
        osr   <= load_val;
        count <= '0;
      end else if (do_out) begin
        osr      <= shift_next;
        out_data <= shift_out;
        count    <= (cnt_sum > {1'b0, FULL_CNT}) ? FULL_CNT : cnt_sum[CNT_W-1:0];
      end
    end
  end

  assign osr_count = count;
  assign osr_value = osr;

endmodule
